// File: rtl/text_render_pkg.sv
// Shared text-mode geometry and defaults for the renderer and its VRAM/font bus.
package text_render_pkg;
  localparam int TR_COLS     = 80;
  localparam int TR_ROWS     = 30;
  localparam int TR_CHAR_W   = 8;
  localparam int TR_CHAR_H   = 16;
  localparam int TR_HPOS_W   = 10;
  localparam int TR_VPOS_W   = 10;
  localparam int TR_ADDR_W   = 12;
  localparam int TR_BLINK_FR = 30;
  localparam int TR_FONT_AW  = 8 + $clog2(TR_CHAR_H);
  localparam logic [7:0] BLANK_CHAR = 8'h20;
endpackage

// File: rtl/text_render_if.sv
// Read-side bus from the text renderer to the VRAM read port and font ROM.
interface text_render_if #(
  parameter int ADDR_W  = 12,
  parameter int CHAR_W  = 8,
  parameter int FONT_AW = 12
);
  logic              vram_ce;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_dout;
  logic [FONT_AW-1:0] font_addr;
  logic [CHAR_W-1:0] font_data;

  modport master (output vram_ce, vram_addr, font_addr, input vram_dout, font_data);
  modport slave  (input vram_ce, vram_addr, font_addr, output vram_dout, font_data);
endinterface

// File: rtl/text_render_cursor_blink.sv
// Cursor blink phase: counts vsync rising edges, toggles phase every BLINK_FR frames.
module text_render_cursor_blink import text_render_pkg::*; #(
  parameter int BLINK_FR = TR_BLINK_FR
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_visible
);
  localparam int CNT_W = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FR - 1);

  logic             r_vs_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hide;
  logic             w_rise;

  assign w_rise = i_vsync & ~r_vs_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_d <= 1'b0;
      r_cnt  <= '0;
      r_hide <= 1'b0;
    end else begin
      r_vs_d <= i_vsync;
      if (w_rise) begin
        if (r_cnt == LAST) begin
          r_cnt  <= '0;
          r_hide <= ~r_hide;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_visible = ~r_hide;
endmodule

// File: rtl/text_render.sv
// Text-mode renderer: per-cell VRAM fetch, font lookup, 1bpp shift-out and cursor overlay.
module text_render import text_render_pkg::*; #(
  parameter int COLS     = TR_COLS,
  parameter int ROWS     = TR_ROWS,
  parameter int CHAR_W   = TR_CHAR_W,
  parameter int CHAR_H   = TR_CHAR_H,
  parameter int HPOS_W   = TR_HPOS_W,
  parameter int VPOS_W   = TR_VPOS_W,
  parameter int ADDR_W   = TR_ADDR_W,
  parameter int BLINK_FR = TR_BLINK_FR
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [HPOS_W-1:0] i_hpos,
  input  logic [VPOS_W-1:0] i_vpos,
  input  logic              i_de,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_vram_busy,
  input  logic [ADDR_W-1:0] i_cursor_addr,
  input  logic              i_cursor_en,
  text_render_if.master     mem_bus,
  output logic              o_pixel,
  output logic              o_de,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_conflict
);
  localparam int COL_SH = $clog2(CHAR_W);
  localparam int ROW_SH = $clog2(CHAR_H);
  localparam logic [HPOS_W-1:0] COLS_H = HPOS_W'(COLS);
  localparam logic [VPOS_W-1:0] ROWS_V = VPOS_W'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  logic [HPOS_W-1:0] w_col_p0;
  logic [VPOS_W-1:0] w_row_p0;
  logic [ADDR_W-1:0] w_addr_p0;
  logic              w_start_p0, w_issue_p0, w_fetch_p0;
  logic [7:0]        w_char_p1;
  logic              w_visible;

  logic              r_run;
  logic              r_vld_p1, r_fetch_p1, r_start_p1;
  logic              r_vld_p2, r_start_p2, r_cur_p2;
  logic [2:0]        r_dhv_p1, r_dhv_p2, r_dhv_p3;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [ROW_SH-1:0] r_grow_p1;
  logic [7:0]        r_char;
  logic [CHAR_W-1:0] r_shift;
  logic              r_inv;
  logic              r_conflict;

  text_render_cursor_blink #(.BLINK_FR(BLINK_FR)) u_blink (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_vsync   (i_vsync),
    .o_visible (w_visible)
  );

  // p0: cell decode and VRAM issue (r_run holds off the first cycle after reset)
  assign w_col_p0   = i_hpos >> COL_SH;
  assign w_row_p0   = i_vpos >> ROW_SH;
  assign w_start_p0 = (i_hpos[COL_SH-1:0] == '0);
  assign w_issue_p0 = r_run & i_de & w_start_p0 & (w_col_p0 < COLS_H) & (w_row_p0 < ROWS_V);
  assign w_fetch_p0 = w_issue_p0 & ~i_vram_busy;
  assign w_addr_p0  = ADDR_W'(w_row_p0) * COLS_A + ADDR_W'(w_col_p0);

  assign mem_bus.vram_ce   = w_fetch_p0;
  assign mem_bus.vram_addr = w_fetch_p0 ? w_addr_p0 : '0;

  // p1: char arrives; a skipped fetch reuses the last latched code
  assign w_char_p1         = r_fetch_p1 ? mem_bus.vram_dout : r_char;
  assign mem_bus.font_addr = r_vld_p1 ? {w_char_p1, r_grow_p1} : '0;

  always_ff @(posedge i_clk) begin
    r_addr_p1 <= w_addr_p0;
    r_grow_p1 <= i_vpos[ROW_SH-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run      <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_fetch_p1 <= 1'b0;
      r_start_p1 <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_start_p2 <= 1'b0;
      r_cur_p2   <= 1'b0;
      r_dhv_p1   <= '0;
      r_dhv_p2   <= '0;
      r_dhv_p3   <= '0;
      r_char     <= BLANK_CHAR;
      r_shift    <= '0;
      r_inv      <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_vld_p1   <= w_issue_p0;
      r_fetch_p1 <= w_fetch_p0;
      r_start_p1 <= w_start_p0;
      r_dhv_p1   <= {i_de, i_hsync, i_vsync};
      if (w_issue_p0 & i_vram_busy) r_conflict <= 1'b1;
      if (r_fetch_p1) r_char <= mem_bus.vram_dout;
      // p2: glyph row arrives from the font ROM
      r_vld_p2   <= r_vld_p1;
      r_start_p2 <= r_start_p1;
      r_cur_p2   <= r_vld_p1 & (r_addr_p1 == i_cursor_addr);
      r_dhv_p2   <= r_dhv_p1;
      // p3: serialise the glyph row, cursor inversion latched for the whole cell
      r_dhv_p3   <= r_dhv_p2;
      if (r_start_p2) begin
        r_shift <= r_vld_p2 ? mem_bus.font_data : '0;
        r_inv   <= r_cur_p2 & i_cursor_en & w_visible;
      end else begin
        r_shift <= r_shift << 1;
      end
    end
  end

  assign o_pixel    = (r_shift[CHAR_W-1] ^ r_inv) & r_dhv_p3[2];
  assign o_de       = r_dhv_p3[2];
  assign o_hsync    = r_dhv_p3[1];
  assign o_vsync    = r_dhv_p3[0];
  assign o_conflict = r_conflict;
endmodule
